// File: rtl/rsa_const_sched.sv
// rsa_const_sched
//   Round-robin scheduler and optional one-entry result cache in front of the
//   Montgomery constant unit (computes R mod N and R^2 mod N for a W-bit N).
//
//   Optional feature macro: RSA_CONST_CACHE_EN
//     defined   : one-entry cache {valid, mod, r, t} plus input cache_inv
//     undefined : no cache, every request runs the constant unit
//
//   Ports
//     clk, rst               clock, asynchronous active-high reset
//     cache_inv              (cache build only) clears the cache entry
//     req_valid[NREQ]        per-requester request
//     req_mod[NREQ*W]        moduli, requester i at [i*W +: W]
//     req_ready[NREQ]        one-hot accept pulse
//     rsp_valid/rsp_ready    result handshake
//     rsp_id, rsp_r, rsp_t   requester index, R mod N, R^2 mod N
//     cu_start, cu_mod       launch pulse and modulus to the constant unit
//     cu_done, cu_r, cu_t    completion pulse and results from the unit
//     busy                   high in every state except IDLE
module rsa_const_sched #(
    parameter int W            = 1024,
    parameter int NREQ         = 2,
    parameter int FLUSH_CYCLES = 3100,
    localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RSA_CONST_CACHE_EN
    input  logic              cache_inv,
`endif
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_mod,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_r,
    output logic [W-1:0]      rsp_t,
    output logic              cu_start,
    output logic [W-1:0]      cu_mod,
    input  logic              cu_done,
    input  logic [W-1:0]      cu_r,
    input  logic [W-1:0]      cu_t,
    output logic              busy
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [W-1:0]   mod_q, mod_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   t_q, t_d;

    logic [W-1:0]   req_mod_arr [NREQ];
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   win_mod;
    logic           cache_hit;
    logic           cache_wr;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mod_slice
        assign req_mod_arr[gi] = req_mod[gi*W +: W];
    end

    // Round-robin pick: lowest requester at or above rr_q, else lowest overall
    // (which is the wrap-around case). Scanning downwards lets the last hit win.
    always_comb begin
        logic           found_hi;
        logic [IDW-1:0] idx_hi;
        logic [IDW-1:0] idx_any;
        found_hi  = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        grant_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                idx_any   = IDW'(i);
                if (i >= int'(rr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = IDW'(i);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_any;
    end

    assign win_mod = req_mod_arr[grant_idx];

`ifdef RSA_CONST_CACHE_EN
    logic         cache_valid_q, cache_valid_d;
    logic [W-1:0] cache_mod_q, cache_r_q, cache_t_q;

    // An invalidate in the accept cycle also suppresses the hit.
    assign cache_hit = cache_valid_q && !cache_inv && (win_mod == cache_mod_q);

    always_comb begin
        cache_valid_d = cache_valid_q;
        if (cache_wr) begin
            cache_valid_d = 1'b1;
        end
        if (cache_inv) begin
            cache_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q <= 1'b0;
            cache_mod_q   <= '0;
            cache_r_q     <= '0;
            cache_t_q     <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            if (cache_wr) begin
                cache_mod_q <= mod_q;
                cache_r_q   <= cu_r;
                cache_t_q   <= cu_t;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        mod_d       = mod_q;
        id_d        = id_q;
        rr_d        = rr_q;
        r_d         = r_q;
        t_d         = t_q;
        req_ready   = '0;
        cache_wr    = 1'b0;
        case (state_q)
            // The constant unit has no reset; wait out any run still in flight.
            S_FLUSH: begin
                if (flush_cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                    flush_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    mod_d                = win_mod;
                    id_d                 = grant_idx;
`ifdef RSA_CONST_CACHE_EN
                    if (cache_hit) begin
                        r_d = cache_r_q;
                        t_d = cache_t_q;
                    end
`endif
                    state_d = cache_hit ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cu_done) begin
                    r_d      = cu_r;
                    t_d      = cu_t;
                    cache_wr = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            mod_q       <= '0;
            id_q        <= '0;
            rr_q        <= '0;
            r_q         <= '0;
            t_q         <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mod_q       <= mod_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            r_q         <= r_d;
            t_q         <= t_d;
        end
    end

    // mod_q only moves on an accept, so the unit may re-read it late in a run.
    assign cu_mod    = mod_q;
    assign cu_start  = (state_q == S_LAUNCH);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_r     = r_q;
    assign rsp_t     = t_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rsa_const_sched.sv
module tb_rsa_const_sched;

    localparam int W     = 8;
    localparam int NREQ  = 2;
    localparam int FLUSH = 40;
    localparam int IDW   = 1;
    localparam int BOUND = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              cache_inv;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_mod;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_r, rsp_t;
    logic              cu_start;
    logic [W-1:0]      cu_mod;
    logic              cu_done;
    logic [W-1:0]      cu_r = '0, cu_t = '0;
    logic              busy;
    logic              m_done = 1'b0;
    logic              spur_done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_dones  = 0;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    assign cu_done = m_done | spur_done;

    rsa_const_sched #(.W(W), .NREQ(NREQ), .FLUSH_CYCLES(FLUSH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RSA_CONST_CACHE_EN
        .cache_inv (cache_inv),
`endif
        .req_valid (req_valid),
        .req_mod   (req_mod),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_t     (rsp_t),
        .cu_start  (cu_start),
        .cu_mod    (cu_mod),
        .cu_done   (cu_done),
        .cu_r      (cu_r),
        .cu_t      (cu_t),
        .busy      (busy)
    );

    // Constant-unit model: no reset, done 20 cycles after start, reads the
    // modulus late (at completion) like the real unit.
    function automatic logic [W-1:0] mod_r(input logic [W-1:0] n);
        if (n == 0) return '0;
        return W'(256 % int'(n));
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (cu_start) begin
            m_cnt    <= 20;
            n_starts <= n_starts + 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done  <= 1'b1;
                cu_r    <= mod_r(cu_mod);
                cu_t    <= (cu_mod == 0) ? '0 : W'((int'(mod_r(cu_mod)) ** 2) % int'(cu_mod));
                n_dones <= n_dones + 1;
            end
        end
    end

    typedef struct {
        logic [1:0] v;
        logic [7:0] n0;
        logic [7:0] n1;
        int         id;
        int         r;
        int         t;
    } vec_t;

    typedef struct {
        int id;
        int r;
        int t;
    } exp_t;

    vec_t tbl [9];
    exp_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_checks();
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_r", 32'(rsp_r), 0);
        check("rst_rsp_t", 32'(rsp_t), 0);
        check("rst_cu_start", 32'(cu_start), 0);
        check("rst_cu_mod", 32'(cu_mod), 0);
        check("rst_busy", 32'(busy), 1);
    endtask

    // Called at negedge+1. Drives a request, waits for the accept, then for the
    // response (optionally holding rsp_ready low for 'hold' cycles), then
    // completes the handshake. Returns the number of cycles waited for accept.
    task automatic serve(input logic [1:0] v, input logic [7:0] n0, input logic [7:0] n1,
                         input int eid, input int er, input int et,
                         input int hold, input bit hit, output int wait_cyc);
        int   k;
        int   starts0;
        bit   saw_rspv;
        bit   saw_ready;
        exp_t e;
        req_valid = v;
        req_mod   = {n1, n0};
        rsp_ready = 1'b0;
        #1;
        k        = 0;
        saw_rspv = 1'b0;
        while (req_ready == '0 && k < BOUND) begin
            if (rsp_valid) saw_rspv = 1'b1;
            @(negedge clk); #1;
            k++;
        end
        wait_cyc = k;
        check("no_rsp_before_accept", 32'(saw_rspv), 0);
        check("accept_grant", 32'(req_ready), 32'(1 << eid));
        e.id = eid; e.r = er; e.t = et;
        exp_q.push_back(e);
        starts0 = n_starts;
        @(negedge clk); #1;
        if (hit) check("hit_latency", 32'(rsp_valid), 1);
        k         = 0;
        saw_ready = 1'b0;
        while (!rsp_valid && k < BOUND) begin
            if (req_ready != '0) saw_ready = 1'b1;
            @(negedge clk); #1;
            k++;
        end
        check("no_ready_in_flight", 32'(saw_ready), 0);
        for (int h = 0; h < hold; h++) begin
            spur_done = (h == 3);
            @(negedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid), 1);
            check("hold_rsp_r", 32'(rsp_r), 32'(er));
            check("hold_rsp_t", 32'(rsp_t), 32'(et));
            check("hold_no_ready", 32'(req_ready), 0);
        end
        spur_done = 1'b0;
        e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_r", 32'(rsp_r), 32'(e.r));
        check("rsp_t", 32'(rsp_t), 32'(e.t));
        check("cu_starts", 32'(n_starts - starts0), hit ? 0 : 1);
        $display("txn: req=%b id=%0d r=%0d t=%0d accept_wait=%0d hit=%0d", v, rsp_id, rsp_r, rsp_t, wait_cyc, hit);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int k;
        int d0;
        tbl[0] = '{2'b01, 8'd13,  8'd11,  0, 9,  3};
        tbl[1] = '{2'b11, 8'd13,  8'd11,  1, 3,  9};
        tbl[2] = '{2'b11, 8'd13,  8'd11,  0, 9,  3};
        tbl[3] = '{2'b11, 8'd13,  8'd11,  1, 3,  9};
        tbl[4] = '{2'b10, 8'd13,  8'd7,   1, 4,  2};
        tbl[5] = '{2'b01, 8'd200, 8'd7,   0, 56, 136};
        tbl[6] = '{2'b10, 8'd200, 8'd255, 1, 1,  1};
        tbl[7] = '{2'b11, 8'd3,   8'd9,   0, 1,  1};
        tbl[8] = '{2'b11, 8'd3,   8'd9,   1, 4,  7};

        rst       = 1'b1;
        cache_inv = 1'b0;
        req_valid = '0;
        req_mod   = '0;
        rsp_ready = 1'b0;
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst = 1'b0;

        // Table: first entry also measures the post-reset flush length.
        for (int i = 0; i < 9; i++) begin
            serve(tbl[i].v, tbl[i].n0, tbl[i].n1, tbl[i].id, tbl[i].r, tbl[i].t, 0, 1'b0, w);
            if (i == 0) check("flush_len", 32'(w), FLUSH);
        end

        // Backpressure: 10 cycles of rsp_ready=0 with both requesters pending,
        // a spurious cu_done lands in RESP during the hold.
        serve(2'b11, 8'd13, 8'd11, 0, 9, 3, 10, 1'b0, w);

        // Spurious cu_done in IDLE.
        spur_done = 1'b1;
        @(negedge clk); #1;
        spur_done = 1'b0;
        check("idle_spur_busy", 32'(busy), 0);
        check("idle_spur_rsp_valid", 32'(rsp_valid), 0);
        check("idle_spur_cu_start", 32'(cu_start), 0);
        @(negedge clk); #1;
        check("idle_spur_busy2", 32'(busy), 0);

        // Reset 5 cycles into a run; the stale done must be ignored.
        req_valid = 2'b10;
        req_mod   = {8'd11, 8'd0};
        #1;
        k = 0;
        while (req_ready == '0 && k < BOUND) begin
            @(negedge clk); #1;
            k++;
        end
        check("midrun_accept", 32'(req_ready), 2);
        @(negedge clk); #1;
        check("midrun_cu_start", 32'(cu_start), 1);
        d0 = n_dones;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks();
        @(negedge clk);
        rst = 1'b0;
        serve(2'b10, 8'd0, 8'd11, 1, 3, 9, 0, 1'b0, w);
        check("flush_len_midrun", 32'(w), FLUSH);
        check("stale_done_plus_new", 32'(n_dones - d0), 2);

`ifdef RSA_CONST_CACHE_EN
        cache_inv = 1'b1;
        @(negedge clk); #1;
        cache_inv = 1'b0;
        serve(2'b01, 8'd13, 8'd0, 0, 9, 3, 0, 1'b0, w);
        serve(2'b01, 8'd13, 8'd0, 0, 9, 3, 0, 1'b1, w);
        cache_inv = 1'b1;
        @(negedge clk); #1;
        cache_inv = 1'b0;
        serve(2'b01, 8'd13, 8'd0, 0, 9, 3, 0, 1'b0, w);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_const_sched.md
# rsa_const_sched

Scheduler and result cache in front of the Montgomery constant unit, which computes R mod N and R² mod N for a W-bit modulus N. It arbitrates round-robin between NREQ requesters (e.g. decrypt and sign cores) and launches the constant unit once per request. It holds the modulus stable for the whole run and returns both constants with a valid/ready handshake. With the cache enabled, a repeat of the last modulus is answered without recomputation.

## Interface
- W, 1024: modulus and constant width
- NREQ, 2: number of requesters; IDW = max(1, ceil(log2(NREQ)))
- FLUSH_CYCLES, 3100: post-reset quiet period; must exceed the worst-case constant-unit run (3077 cycles at W=1024)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_mod  in  NREQ*W  moduli; slice i = [i*W +: W]
- req_ready  out  NREQ  one-hot one-cycle accept pulse
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  IDW  requester index of the result
- rsp_r  out  W  R mod N
- rsp_t  out  W  R² mod N
- cu_start  out  1  start pulse to the constant unit
- cu_mod  out  W  modulus to the constant unit
- cu_done  in  1  one-cycle completion pulse
- cu_r, cu_t  in  W  constant-unit results
- busy  out  1  high in any state except IDLE

## Operation
- States: FLUSH, IDLE, LAUNCH, WAIT, RESP. Reset enters FLUSH.
- **FLUSH**
  - The constant unit has no reset and may still be mid-run, so the controller counts FLUSH_CYCLES clocks.
  - cu_done is ignored in this state.
  - Goes to IDLE when the count expires.
- **IDLE**
  - If any req_valid is high, the winner is the first set bit at or after rr_ptr, wrapping at NREQ.
  - Latch the winner's modulus into mod_q and its index into id_q. Pulse the winner's req_ready.
  - Cache hit: go to RESP with the cached constants.
  - Otherwise: go to LAUNCH.
- **LAUNCH**
  - cu_start=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On cu_done, capture cu_r and cu_t into rsp_r and rsp_t and update the cache. Go to RESP.
- **RESP**
  - rsp_valid=1; rsp_id, rsp_r and rsp_t are held stable.
  - On rsp_valid&&rsp_ready, set rr_ptr=(id_q+1) mod NREQ and go to IDLE.
- cu_mod is driven from mod_q at all times. mod_q changes only on an IDLE accept, so the modulus is stable through the unit's late re-read of its modulus input.
- A cu_done outside WAIT is ignored.
- A requester must hold req_valid and its modulus until its req_ready. Simultaneous requests are served strictly round-robin.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_t=0
  - cu_start=0, cu_mod=0, busy=1
  - rr_ptr=0, cache invalid

## Timing
- Accept at cycle T (req_ready high at T).
- Miss: cu_start at T+1. If cu_done arrives at D, rsp_valid is high from D+1.
- Hit: rsp_valid is high from T+1.
- Next accept is no earlier than 1 cycle after the rsp handshake. There is one request in flight at a time.
- rst asserted mid-run: all outputs take their reset values immediately and the block returns to FLUSH. Any response is lost; the requester must re-request.

## Configuration
- RSA_CONST_CACHE_EN
  - **Defined:** one-entry cache (valid, mod, r, t), written on every cu_done in WAIT. Hit when valid && req_mod == mod. Adds input cache_inv (1 bit): when high in any state, it clears valid in that cycle; it has priority over a same-cycle write.
  - **Undefined:** no cache storage and no cache_inv port; every request goes through LAUNCH and WAIT.

## Test plan
Bench uses W=8, FLUSH_CYCLES=40 and a constant-unit model that pulses done 20 cycles after start.
- After reset, hold req_valid[0]=1 with N=13 → no req_ready before cycle 40. Then rsp_r=9 and rsp_t=3 (256 mod 13, 81 mod 13), rsp_id=0.
- req_valid=2'b11 every cycle, N0=13, N1=11 → grants alternate 0,1,0,1. The second result is rsp_r=3, rsp_t=9 (256 mod 11, 9 mod 11).
- Hold rsp_ready=0 for 10 cycles → rsp_valid and data stay stable, and no new req_ready is issued.
- With RSA_CONST_CACHE_EN: two requests with N=13 → one cu_start total, and the second result arrives 1 cycle after accept. Pulse cache_inv, then request N=13 again → a cu_start occurs.
- Assert rst 5 cycles after cu_start, release, let the model's stale done fire at +20 → the stale done is ignored, rsp_valid stays 0, and FLUSH completes before the next req_ready.
- Inject a spurious cu_done pulse in IDLE and in RESP → there is no state change and rsp data is unchanged.
